// File: rtl/load_align_unit.sv
// Load data path between MEM and a word-wide synchronous RAM: issues one or two
// word reads, merges the addressed bytes and sign/zero-extends the result.
module load_align_unit #(
    parameter int          XLEN        = 32,
    parameter int          ADDR_W      = 32,
    parameter bit          MISALIGN_EN = 1'b1,
    localparam int         OFFS_W      = $clog2(XLEN / 8)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [2:0]               req_funct3,
    output logic                     mem_rd_en,
    output logic [ADDR_W-OFFS_W-1:0] mem_addr,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_data,
    output logic                     resp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_WAIT1,
        S_ERR,
        S_RESP
    } state_t;

    state_t                     r_state;
    logic [OFFS_W-1:0]          r_offs;
    logic [2:0]                 r_funct3;
    logic                       r_split;
    logic [XLEN-1:0]            r_lo;
    logic                       r_mem_rd_en;
    logic [ADDR_W-OFFS_W-1:0]   r_mem_addr;
    logic                       r_resp_valid;
    logic                       r_resp_err;
    logic [XLEN-1:0]            r_resp_data;

    logic                       w_req_illegal;
    logic                       w_req_split;
    logic [XLEN-1:0]            w_lo;
    logic [2*XLEN-1:0]          w_pair;
    logic [XLEN-1:0]            w_shift;
    logic [XLEN-1:0]            w_mask;
    logic                       w_msb;
    logic [XLEN-1:0]            w_ext;

    // Request decode only steers the next state; it never reaches an output directly.
    always_comb begin
        w_req_illegal = (req_funct3 == 3'b111) ||
                        ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        w_req_split   = (32'(req_addr[OFFS_W-1:0]) + (32'd1 << req_funct3[1:0])) > 32'(XLEN / 8);
    end

    // The low word is still on mem_rdata in WAIT0, so the result is ready as RESP is entered.
    always_comb begin
        w_lo    = (r_state == S_WAIT0) ? mem_rdata : r_lo;
        w_pair  = {mem_rdata, w_lo};
        w_shift = XLEN'(w_pair >> {r_offs, 3'b000});
        case (r_funct3[1:0])
            2'd0: begin
                w_mask = XLEN'(8'hFF);
                w_msb  = w_shift[7];
            end
            2'd1: begin
                w_mask = XLEN'(16'hFFFF);
                w_msb  = w_shift[15];
            end
            2'd2: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_msb  = w_shift[31];
            end
            default: begin
                w_mask = '1;
                w_msb  = w_shift[XLEN-1];
            end
        endcase
        w_ext = (w_shift & w_mask) | ((!r_funct3[2] && w_msb) ? ~w_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_offs     <= req_addr[OFFS_W-1:0];
                        r_funct3   <= req_funct3;
                        r_split    <= w_req_split;
                        r_mem_addr <= req_addr[ADDR_W-1:OFFS_W];
                        if (w_req_illegal || (w_req_split && !MISALIGN_EN)) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state     <= S_ISSUE0;
                            r_mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_ISSUE0: begin
                    r_state     <= S_WAIT0;
                    r_mem_rd_en <= r_split;
                    if (r_split) begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                S_WAIT0: begin
                    r_lo        <= mem_rdata;
                    r_mem_rd_en <= 1'b0;
                    if (r_split) begin
                        r_state <= S_WAIT1;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= w_ext;
                    end
                end
                S_WAIT1: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= w_ext;
                end
                S_ERR: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_data  <= '0;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized and directed bench for load_align_unit: three instances (32-bit split,
// 32-bit no-split, 64-bit) checked against a byte-level load model.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [2:0]  mem_rd_en;
    logic [29:0] ma0, ma1;
    logic [28:0] ma2;
    logic [31:0] rd0 = '0, rd1 = '0;
    logic [63:0] rd2 = '0;
    logic [2:0]  resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] rdat0, rdat1;
    logic [63:0] rdat2;
    logic [2:0]  resp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          s;
        logic [31:0] a;
        int          t;
    } rd_t;
    rd_t rq[$];

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en[0]),
        .mem_addr(ma0), .mem_rdata(rd0), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready), .resp_data(rdat0), .resp_err(resp_err[0]));

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en[1]),
        .mem_addr(ma1), .mem_rdata(rd1), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready), .resp_data(rdat1), .resp_err(resp_err[1]));

    load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en[2]),
        .mem_addr(ma2), .mem_rdata(rd2), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready), .resp_data(rdat2), .resp_err(resp_err[2]));

    function automatic logic [31:0] ram32(input logic [31:0] w);
        if (w == 32'h10) return 32'h8899AABB;
        if (w == 32'h11) return 32'h11223344;
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [63:0] ram64(input logic [31:0] w);
        if (w == 32'h10) return 64'h12345678_F0000000;
        return {(w * 32'h85EBCA6B) ^ 32'h0F0F1234, (w * 32'hC2B2AE35) ^ 32'hDEAD0001};
    endfunction

    // Data is valid only the cycle after a strobe; otherwise the bus carries noise.
    always @(posedge clk) begin
        rd0 <= mem_rd_en[0] ? ram32(32'(ma0)) : $urandom;
        rd1 <= mem_rd_en[1] ? ram32(32'(ma1)) : $urandom;
        rd2 <= mem_rd_en[2] ? ram64({3'b000, ma2}) : {$urandom, $urandom};
        if (mem_rd_en[0]) rq.push_back('{0, 32'(ma0), cyc_cnt});
        if (mem_rd_en[1]) rq.push_back('{1, 32'(ma1), cyc_cnt});
        if (mem_rd_en[2]) rq.push_back('{2, {3'b000, ma2}, cyc_cnt});
        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] g_data(input int s);
        case (s)
            0: return {32'b0, rdat0};
            1: return {32'b0, rdat1};
            default: return rdat2;
        endcase
    endfunction

    // Byte-by-byte little-endian load model.
    function automatic void model(input int xl, input bit mis, input logic [31:0] addr,
                                  input logic [2:0] f3, output logic [63:0] data,
                                  output bit err, output int lat, output int nrd);
        int nb, size, off;
        bit illegal, split;
        logic [31:0] ba, wa;
        logic [63:0] w;
        nb      = xl / 8;
        size    = 1 << f3[1:0];
        off     = int'(addr % nb);
        illegal = (f3 == 3'b111) || (xl == 32 && (f3 == 3'b011 || f3 == 3'b110));
        split   = (off + size) > nb;
        data    = '0;
        if (illegal || (split && !mis)) begin
            err = 1'b1; lat = 2; nrd = 0;
            return;
        end
        err = 1'b0;
        for (int i = 0; i < size; i++) begin
            ba = addr + 32'(i);
            wa = ba / nb;
            w  = (xl == 32) ? {32'b0, ram32(wa)} : ram64(wa);
            w  = w >> (8 * (ba % nb));
            data = data | ({56'b0, w[7:0]} << (8 * i));
        end
        if (!f3[2] && data[8*size-1]) data = data | ~((64'd1 << (8 * size)) - 64'd1);
        if (xl == 32) data = data & 64'hFFFF_FFFF;
        lat = split ? 4 : 3;
        nrd = split ? 2 : 1;
    endfunction

    task automatic do_load(input int s, input logic [31:0] addr, input logic [2:0] f3,
                           input int hold, output logic [63:0] got);
        int xl, lat, nrd, cyc, nb;
        bit err;
        logic [63:0] exp_d;
        logic [31:0] wmask, w0;
        xl    = (s == 2) ? 64 : 32;
        nb    = xl / 8;
        wmask = (s == 2) ? 32'h1FFF_FFFF : 32'h3FFF_FFFF;
        w0    = addr / nb;
        model(xl, (s != 1), addr, f3, exp_d, err, lat, nrd);
        got = '0;
        @(negedge clk);
        rq.delete();
        req_addr   = addr;
        req_funct3 = f3;
        req_valid[s] = 1'b1;
        check_eq("req_ready_idle", 64'(req_ready[s]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        cyc = 1;
        while (!resp_valid[s] && cyc < 12) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", 64'(cyc), 64'(lat));
        if (resp_valid[s]) begin
            got = g_data(s);
            check_eq("resp_data", got, exp_d);
            check_eq("resp_err", 64'(resp_err[s]), 64'(err));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                check_eq("hold_valid", 64'(resp_valid[s]), 64'd1);
                check_eq("hold_data", g_data(s), exp_d);
                check_eq("hold_ready", 64'(req_ready[s]), 64'd0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            check_eq("post_valid", 64'(resp_valid[s]), 64'd0);
            check_eq("post_ready", 64'(req_ready[s]), 64'd1);
        end else begin
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
        end
        check_eq("num_reads", 64'(rq.size()), 64'(nrd));
        if (rq.size() >= 1) begin
            check_eq("rd0_inst", 64'(rq[0].s), 64'(s));
            check_eq("rd0_addr", 64'(rq[0].a), 64'(w0));
        end
        if (rq.size() >= 2) begin
            check_eq("rd1_addr", 64'(rq[1].a), 64'((w0 + 32'd1) & wmask));
            check_eq("rd1_consec", 64'(rq[1].t - rq[0].t), 64'd1);
        end
        $display("TXN inst=%0d addr=%08h f3=%0d data=%016h err=%0d lat=%0d reads=%0d",
                 s, addr, f3, got, err, cyc, rq.size());
    endtask

    initial begin
        logic [63:0] got;
        logic [31:0] a;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check_eq("rst_resp_data", {rdat0 | rdat1, 32'b0} | rdat2, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 64'(req_ready), 64'd7);

        do_load(0, 32'h43, 3'b000, 0, got); check_eq("lb_43", got, 64'hFFFFFF88);
        do_load(0, 32'h43, 3'b101, 0, got); check_eq("lhu_43", got, 64'h00004488);
        do_load(0, 32'h42, 3'b010, 0, got); check_eq("lw_42", got, 64'h33448899);
        do_load(0, 32'h40, 3'b001, 0, got); check_eq("lh_40", got, 64'hFFFFAABB);
        do_load(0, 32'h40, 3'b010, 0, got); check_eq("lw_40", got, 64'h8899AABB);
        do_load(1, 32'h41, 3'b010, 0, got); check_eq("na_lw_41", got, 64'h0);
        do_load(0, 32'h40, 3'b011, 0, got); check_eq("ld_on_32", got, 64'h0);
        do_load(0, 32'h40, 3'b010, 5, got); check_eq("lw_hold", got, 64'h8899AABB);
        do_load(0, 32'hFFFF_FFFF, 3'b001, 0, got);
        do_load(2, 32'h80, 3'b110, 0, got); check_eq("lwu_64", got, 64'h00000000F0000000);
        do_load(2, 32'h80, 3'b010, 0, got); check_eq("lw_64", got, 64'hFFFFFFFFF0000000);
        do_load(2, 32'h84, 3'b011, 2, got);

        // Reset while the first read is outstanding must abandon the load silently.
        @(negedge clk);
        req_addr = 32'h40; req_funct3 = 3'b010; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_ready", 64'(req_ready[0]), 64'd0);
        check_eq("midrst_rd_en", 64'(mem_rd_en[0]), 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid[0]) seen = 1'b1;
        end
        check_eq("midrst_no_resp", 64'(seen), 64'd0);
        check_eq("midrst_idle", 64'(req_ready[0]), 64'd1);
        do_load(0, 32'h42, 3'b010, 0, got); check_eq("after_midrst", got, 64'h33448899);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom : 32'h40 + 32'($urandom_range(0, 15));
            do_load(i % 3, a, 3'($urandom_range(0, 7)), $urandom_range(0, 2), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
